// File: rtl/mux_rr_arbiter_if.sv
// Bundle of handshake and datapath signals for mux_rr_arbiter.
// Parameters:
//   N     - number of requesters / mux inputs
//   SEL_W - select width
// Signals:
//   req, done, in                        - driven by the requesting side (master)
//   sel, gnt, busy, mux_out, preempt     - driven by the arbiter (slave)
interface mux_rr_arbiter_if #(
    parameter int N     = 16,
    parameter int SEL_W = 4
);
    logic [N-1:0]     req;
    logic             done;
    logic [N-1:0]     in;
    logic [SEL_W-1:0] sel;
    logic [N-1:0]     gnt;
    logic             busy;
    logic             mux_out;
    logic             preempt;

    modport master (
        output req, done, in,
        input  sel, gnt, busy, mux_out, preempt
    );

    modport slave (
        input  req, done, in,
        output sel, gnt, busy, mux_out, preempt
    );
endinterface

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter with hold timer in front of an N:1 single-bit mux.
// One requester owns the mux at a time; its index drives the select and
// the selected data bit is presented on mux_out while the grant is held.
// A grant held for MAX_HOLD cycles while others wait is revoked (preempt).
// Ports:
//   clk  - rising-edge clock
//   rst  - asynchronous active-high reset
//   bus  - mux_rr_arbiter_if.slave: req/done/in in, sel/gnt/busy/mux_out/preempt out
module mux_rr_arbiter #(
    parameter int N        = 16,
    parameter int SEL_W    = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic          clk,
    input  logic          rst,
    mux_rr_arbiter_if.slave bus
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;
    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    logic [0:0]       state_r;
    logic [SEL_W-1:0] ptr_r;
    logic [SEL_W-1:0] sel_r;
    logic [N-1:0]     gnt_r;
    logic             busy_r;
    logic             preempt_r;
    logic [7:0]       hcnt_r;

    logic [SEL_W-1:0] winner_s;
    logic             found_s;
    logic             owner_req_s;
    logic             others_s;
    logic             norm_rel_s;
    logic             tmo_rel_s;

    // (v + k) mod N for v < N and k < N
    function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v,
                                                  input int unsigned k);
        int unsigned sum;
        sum = int'(v) + k;
        if (sum >= N) begin
            sum = sum - N;
        end else begin
            sum = sum;
        end
        return SEL_W'(sum);
    endfunction

    // Round-robin scan starting at ptr_r: first requesting index wins
    always_comb begin
        winner_s = ptr_r;
        found_s  = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (!found_s && bus.req[wrap_inc(ptr_r, k)]) begin
                winner_s = wrap_inc(ptr_r, k);
                found_s  = 1'b1;
            end else begin
                found_s  = found_s;
            end
        end
    end

    // Release conditions; a normal release has priority over a timeout
    always_comb begin
        owner_req_s = bus.req[sel_r];
        others_s    = |(bus.req & ~gnt_r);
        norm_rel_s  = bus.done | ~owner_req_s;
        tmo_rel_s   = (hcnt_r == HOLD_LAST) & others_s;
    end

    // Arbitration state machine and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            ptr_r     <= {SEL_W{1'b0}};
            sel_r     <= {SEL_W{1'b0}};
            gnt_r     <= {N{1'b0}};
            busy_r    <= 1'b0;
            preempt_r <= 1'b0;
            hcnt_r    <= 8'd0;
        end else begin
            preempt_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (found_s) begin
                        sel_r   <= winner_s;
                        gnt_r   <= {{(N-1){1'b0}}, 1'b1} << winner_s;
                        busy_r  <= 1'b1;
                        hcnt_r  <= 8'd0;
                        state_r <= BUSY;
                    end
                end
                BUSY: begin
                    if (norm_rel_s || tmo_rel_s) begin
                        // sel keeps the last owner; IDLE lasts at least one cycle
                        gnt_r     <= {N{1'b0}};
                        busy_r    <= 1'b0;
                        ptr_r     <= wrap_inc(sel_r, 32'd1);
                        preempt_r <= ~norm_rel_s;
                        state_r   <= IDLE;
                    end else if (hcnt_r != HOLD_LAST) begin
                        hcnt_r <= hcnt_r + 8'd1;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    gnt_r   <= {N{1'b0}};
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.sel     = sel_r;
    assign bus.gnt     = gnt_r;
    assign bus.busy    = busy_r;
    assign bus.preempt = preempt_r;
    assign bus.mux_out = busy_r ? bus.in[sel_r] : 1'b0;
endmodule

// File: tb/tb_mux_rr_arbiter.sv
module tb_mux_rr_arbiter;
    localparam int N        = 16;
    localparam int SEL_W    = 4;
    localparam int MAX_HOLD = 8;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    mux_rr_arbiter_if #(.N(N), .SEL_W(SEL_W)) bus ();

    mux_rr_arbiter #(.N(N), .SEL_W(SEL_W), .MAX_HOLD(MAX_HOLD)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    int m_owner;   // -1 when nobody owns the mux
    int m_sel;
    int m_ptr;
    int m_held;    // cycles the current owner has completed
    bit m_pre;

    task automatic model_step();
        int w;
        bit others;
        if (rst) begin
            m_owner = -1; m_sel = 0; m_ptr = 0; m_held = 0; m_pre = 1'b0;
        end else if (m_owner < 0) begin
            m_pre = 1'b0;
            w = -1;
            for (int k = 0; k < N; k++) begin
                if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
            end
            if (w >= 0) begin
                m_owner = w; m_sel = w; m_held = 0;
            end
        end else begin
            m_held = m_held + 1;
            others = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (i != m_owner && bus.req[i]) others = 1'b1;
            end
            if (bus.done || !bus.req[m_owner]) begin
                m_owner = -1; m_ptr = (m_sel + 1) % N; m_pre = 1'b0;
            end else if (m_held >= MAX_HOLD && others) begin
                m_owner = -1; m_ptr = (m_sel + 1) % N; m_pre = 1'b1;
            end else begin
                m_pre = 1'b0;
            end
        end
    endtask

    initial begin
        m_owner = -1; m_sel = 0; m_ptr = 0; m_held = 0; m_pre = 1'b0;
        forever begin
            @(posedge clk or posedge rst);
            model_step();
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model every cycle, away from the active edge
    initial begin
        logic [15:0] e_gnt;
        logic        e_busy;
        logic        e_mux;
        forever begin
            @(negedge clk);
            e_busy = (m_owner >= 0);
            e_gnt  = e_busy ? (16'h0001 << m_owner) : 16'h0000;
            e_mux  = e_busy ? bus.in[m_sel] : 1'b0;
            chk("model_gnt",     {16'h0, bus.gnt},     {16'h0, e_gnt});
            chk("model_busy",    {31'h0, bus.busy},    {31'h0, e_busy});
            chk("model_sel",     {28'h0, bus.sel},     32'(m_sel));
            chk("model_preempt", {31'h0, bus.preempt}, {31'h0, m_pre});
            chk("model_mux_out", {31'h0, bus.mux_out}, {31'h0, e_mux});
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1; bus.req = 16'h0000; bus.done = 1'b0;
        step(1);
        rst = 1'b0;
    endtask

    initial begin
        int rr_order [6];
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.req  = 16'hFFFF;
        bus.done = 1'b0;
        bus.in   = 16'($urandom);

        // Reset with everyone requesting
        step(2);
        chk("rst_gnt",  {16'h0, bus.gnt},     32'h0);
        chk("rst_busy", {31'h0, bus.busy},    32'h0);
        chk("rst_sel",  {28'h0, bus.sel},     32'h0);
        chk("rst_mux",  {31'h0, bus.mux_out}, 32'h0);
        rst = 1'b0;
        step(1);
        chk("first_gnt", {16'h0, bus.gnt}, 32'h0001);
        chk("first_sel", {28'h0, bus.sel}, 32'h0);
        bus.req = 16'h0000;
        step(1);
        chk("first_release", {31'h0, bus.busy}, 32'h0);

        // Single requester holds 20 cycles without preemption
        bus.req = 16'h0020;
        bus.in  = 16'h0020;
        step(1);
        chk("single_gnt", {16'h0, bus.gnt},     32'h0020);
        chk("single_sel", {28'h0, bus.sel},     32'h5);
        chk("single_mux", {31'h0, bus.mux_out}, 32'h1);
        for (int i = 0; i < 20; i++) begin
            step(1);
            chk("single_hold_gnt", {16'h0, bus.gnt},     32'h0020);
            chk("single_hold_pre", {31'h0, bus.preempt}, 32'h0);
        end
        bus.done = 1'b1;
        step(1);
        chk("single_done_gnt", {16'h0, bus.gnt}, 32'h0);
        chk("single_done_sel", {28'h0, bus.sel}, 32'h5);
        bus.done = 1'b0;
        bus.req  = 16'h0000;

        // Round robin over indices 1,4,7 with done one cycle after each grant
        do_reset();
        rr_order = '{1, 4, 7, 1, 4, 7};
        bus.in  = 16'h0090;
        bus.req = 16'h0092;
        for (int i = 0; i < 6; i++) begin
            step(1);
            chk("rr_sel", {28'h0, bus.sel}, 32'(rr_order[i]));
            chk("rr_gnt", {16'h0, bus.gnt}, 32'h1 << rr_order[i]);
            bus.done = 1'b1;
            step(1);
            chk("rr_idle", {31'h0, bus.busy}, 32'h0);
            bus.done = 1'b0;
        end
        bus.req = 16'h0000;
        step(1);

        // Timeout between two continuous requesters
        do_reset();
        bus.in  = 16'h0002;
        bus.req = 16'h0003;
        step(1);
        chk("tmo_gnt0", {16'h0, bus.gnt}, 32'h0001);
        for (int i = 1; i < MAX_HOLD; i++) begin
            step(1);
            chk("tmo_hold0", {16'h0, bus.gnt},     32'h0001);
            chk("tmo_nopre0", {31'h0, bus.preempt}, 32'h0);
        end
        step(1);
        chk("tmo_rel0_gnt", {16'h0, bus.gnt},     32'h0);
        chk("tmo_rel0_pre", {31'h0, bus.preempt}, 32'h1);
        step(1);
        chk("tmo_gnt1",     {16'h0, bus.gnt},     32'h0002);
        chk("tmo_pre_drop", {31'h0, bus.preempt}, 32'h0);
        for (int i = 1; i < MAX_HOLD; i++) begin
            step(1);
            chk("tmo_hold1", {16'h0, bus.gnt}, 32'h0002);
        end
        step(1);
        chk("tmo_rel1_pre", {31'h0, bus.preempt}, 32'h1);
        step(1);
        chk("tmo_back_to_0", {16'h0, bus.gnt}, 32'h0001);
        bus.req = 16'h0000;
        step(2);

        // done coinciding with the timeout edge is a normal release
        do_reset();
        bus.req = 16'h0003;
        step(1);
        chk("dt_gnt0", {16'h0, bus.gnt}, 32'h0001);
        step(MAX_HOLD - 1);
        bus.done = 1'b1;
        step(1);
        chk("dt_busy", {31'h0, bus.busy},    32'h0);
        chk("dt_pre",  {31'h0, bus.preempt}, 32'h0);
        bus.done = 1'b0;
        step(1);
        chk("dt_next_gnt", {16'h0, bus.gnt}, 32'h0002);
        chk("dt_next_sel", {28'h0, bus.sel}, 32'h1);
        bus.req = 16'h0000;
        step(2);

        // Asynchronous reset in the middle of a grant
        bus.req = 16'h0200;
        bus.in  = 16'h0200;
        step(1);
        chk("ar_gnt9", {16'h0, bus.gnt}, 32'h0200);
        step(2);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("ar_gnt_clear",  {16'h0, bus.gnt},  32'h0);
        chk("ar_busy_clear", {31'h0, bus.busy}, 32'h0);
        step(1);
        rst = 1'b0;
        step(1);
        chk("ar_regrant_gnt", {16'h0, bus.gnt},     32'h0200);
        chk("ar_regrant_sel", {28'h0, bus.sel},     32'h9);
        chk("ar_regrant_mux", {31'h0, bus.mux_out}, 32'h1);
        step(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

- Shares a 16:1 single-bit multiplexer between up to N requesters using round-robin arbitration with a hold timer.
- Grants one requester at a time and drives the mux select from the granted index.
- Presents the selected bit as a gated output.
- Sits in front of the N-bit multiplexer datapath and replaces the static select input with a scheduled one.

## Interface
- N, 16: number of requesters/mux inputs; legal 2..16.
- SEL_W, 4: select width; N ≤ 2^SEL_W.
- MAX_HOLD, 8: cycles a grant may be held while other requests wait; legal 2..255.

- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- req  input  N  per-requester request level.
- done  input  1  current owner releases its grant; ignored when not busy.
- in  input  N  mux data inputs; in[i] belongs to requester i.
- sel  output  SEL_W  registered index of the current or last owner.
- gnt  output  N  registered one-hot grant; all zero when idle.
- busy  output  1  registered; 1 while a grant is held.
- mux_out  output  1  combinational in[sel] when busy=1, else 0.
- preempt  output  1  registered one-cycle pulse on a timeout release.

## Operation
- Reset values (async, immediate):
  - State IDLE.
  - sel=0, gnt=0, busy=0, preempt=0.
  - Round-robin pointer ptr=0, hold counter hcnt=0.
- IDLE:
  - If req≠0, winner = first index i with req[i]=1, scanning ptr, ptr+1, …, N-1, 0, …, ptr-1 (mod N).
  - At the clock edge: sel←winner, gnt←one-hot(winner), busy←1, hcnt←0; go to BUSY.
  - If req=0, remain in IDLE; all outputs hold.
- BUSY, evaluated each edge in priority order:
  1. done=1 or req[sel]=0: normal release.
  2. hcnt=MAX_HOLD-1 and (req & ~gnt)≠0: timeout release; preempt←1 for one cycle.
  3. Otherwise: hcnt←hcnt+1, saturating at MAX_HOLD-1.
- On any release:
  - gnt←0, busy←0, ptr←(sel+1) mod N; go to IDLE.
  - sel keeps its value.
- A lone requester is never preempted. Its hcnt saturates and it keeps the grant until done or req drops.
- The IDLE state after every release lasts at least one cycle (bus turnaround); there are no back-to-back grants.
- Requests to indices ≥N do not exist; req bits are N wide.
- req bits other than the owner's are ignored in BUSY except for the timeout check.
- done together with a timeout is a normal release; preempt stays 0.
- No fairness state other than ptr. A requester that drops req before being granted loses nothing.

## Timing
- Grant latency: a req sampled at edge k in IDLE gives gnt/sel/busy valid after edge k; mux_out is valid in the same cycle.
- Release: done sampled at edge k drops gnt after edge k. The earliest next grant is after edge k+1.
- Timeout: with owner grant taken at edge g and competitors present throughout, hcnt reaches MAX_HOLD-1 after edge g+MAX_HOLD-1. Release and preempt=1 occur after edge g+MAX_HOLD. The owner holds for exactly MAX_HOLD cycles.
- Worst-case wait for a continuously requesting input: (N-1)·(MAX_HOLD+1) cycles.
- rst asserted mid-grant clears gnt/busy immediately, with no clock needed. After deassertion, arbitration restarts from ptr=0.

## Test plan
- Reset: rst=1 with req=16'hFFFF and random in -> gnt=0, busy=0, sel=0, mux_out=0. After release, the first grant goes to index 0.
- Single requester: req=16'h0020, in[5]=1 -> after one edge gnt=16'h0020, sel=5, mux_out=1. Holds for 20 cycles with no preempt. done=1 -> gnt=0 next edge.
- Round robin: req=16'h0092 (indices 1,4,7) held high, each owner pulses done one cycle after grant -> grant order 1,4,7,1,… with one idle cycle between grants.
- Timeout: req=16'h0003 held, no done, MAX_HOLD=8 -> index 0 holds exactly 8 cycles, preempt pulses once, then a 1-cycle idle, then index 1 is granted for 8 cycles.
- Simultaneous done and timeout on cycle MAX_HOLD -> release with preempt=0; the next grant goes to the next requester after sel.
- Async reset mid-grant: owner=9 busy, assert rst between edges -> gnt=0 and busy=0 without a clock edge. With req=16'h0200 after reset, grant 9 returns one edge after rst deasserts.
